fifo_frame_tx: RTL

//   Downstream consumer of the 64->8 asymmetric FWFT sync FIFO. Drains bytes from the FIFO
//   and emits fixed-length frames on a byte stream with valid/ready handshake.

---
 rtl/fifo_frame_tx_pkg.sv | 16 +
 rtl/fifo_frame_tx_csum_acc.sv | 35 +++
 rtl/fifo_frame_tx.sv | 147 ++++++++++++++
 3 files changed

// File: rtl/fifo_frame_tx_pkg.sv
// Shared definitions for the FIFO frame transmitter: FSM encodings, default markers
// and checksum width. The RX checker is expected to import this package as well.
package fifo_frame_tx_pkg;

    typedef logic [2:0] state_t;

    localparam state_t ST_IDLE    = 3'd0;
    localparam state_t ST_SOF     = 3'd1;
    localparam state_t ST_LEN     = 3'd2;
    localparam state_t ST_PAYLOAD = 3'd3;
    localparam state_t ST_CSUM    = 3'd4;

    localparam logic [7:0] DEFAULT_SOF_BYTE = 8'hA5;
    localparam int         CSUM_W           = 8;

endpackage

// File: rtl/fifo_frame_tx_csum_acc.sv
// Additive modulo-2^CSUM_W accumulator with synchronous clear and enable.
// Clear takes priority so a frame start always begins from zero.
module frame_csum_acc
    import fifo_frame_tx_pkg::*;
(
    input  logic              sys_clk,
    input  logic              sys_rst,
    input  logic              clr_i,
    input  logic              en_i,
    input  logic [CSUM_W-1:0] din_i,
    output logic [CSUM_W-1:0] sum_o
);

    logic [CSUM_W-1:0] acc_q, acc_d;

    always_comb begin
        acc_d = acc_q;
        if (clr_i) begin
            acc_d = '0;
        end else if (en_i) begin
            acc_d = acc_q + din_i;
        end
    end

    always_ff @(posedge sys_clk or negedge sys_rst) begin
        if (!sys_rst) begin
            acc_q <= '0;
        end else begin
            acc_q <= acc_d;
        end
    end

    assign sum_o = acc_q;

endmodule

// File: rtl/fifo_frame_tx.sv
// Drains bytes from a FWFT FIFO and emits fixed-length frames (SOF, LEN, payload,
// checksum) on a valid/ready byte stream with a single registered output slot.
module fifo_frame_tx
    import fifo_frame_tx_pkg::*;
#(
    parameter int         FRAME_LEN = 8,
    parameter logic [7:0] SOF_BYTE  = DEFAULT_SOF_BYTE,
    parameter int         CNT_W     = 8
)
(
    input  logic             sys_clk,
    input  logic             sys_rst,
    input  logic [7:0]       fifo_dout,
    input  logic             fifo_empty,
    input  logic [CNT_W-1:0] fifo_rd_data_count,
    output logic             fifo_rd_en,
    output logic [7:0]       m_data,
    output logic             m_valid,
    output logic             m_last,
    input  logic             m_ready,
    output logic             busy,
    output logic             underrun,
    output logic [15:0]      frame_cnt
);

    localparam logic [7:0]       LEN_BYTE      = 8'(FRAME_LEN);
    localparam logic [7:0]       LAST_IDX      = 8'(FRAME_LEN - 1);
    localparam logic [CNT_W-1:0] FRAME_LEN_CNT = CNT_W'(FRAME_LEN);

    state_t      state_q, state_d;
    logic [7:0]  m_data_q, m_data_d;
    logic        m_valid_q, m_valid_d;
    logic        m_last_q, m_last_d;
    logic [7:0]  idx_q, idx_d;
    logic        underrun_q, underrun_d;
    logic [15:0] frame_cnt_q, frame_cnt_d;

    logic              slot_free;
    logic              start_frame;
    logic              pop;
    logic              csum_clr;
    logic [CSUM_W-1:0] csum;

    // The output slot can take a new beat when empty or when its beat leaves this cycle.
    assign slot_free   = !m_valid_q || m_ready;
    assign start_frame = (state_q == ST_IDLE) && slot_free && (fifo_rd_data_count >= FRAME_LEN_CNT);
    assign pop         = sys_rst && (state_q == ST_PAYLOAD) && slot_free && !fifo_empty;

    frame_csum_acc u_csum (
        .sys_clk (sys_clk),
        .sys_rst (sys_rst),
        .clr_i   (csum_clr),
        .en_i    (pop),
        .din_i   (fifo_dout),
        .sum_o   (csum)
    );

    always_comb begin
        state_d    = state_q;
        m_data_d   = m_data_q;
        m_valid_d  = m_valid_q;
        m_last_d   = m_last_q;
        idx_d      = idx_q;
        underrun_d = 1'b0;
        csum_clr   = 1'b0;

        // A beat that is leaving is dropped unless a state below reloads the slot.
        if (slot_free) begin
            m_valid_d = 1'b0;
            m_last_d  = 1'b0;
        end

        case (state_q)
            ST_IDLE: begin
                if (start_frame) begin
                    m_data_d  = SOF_BYTE;
                    m_valid_d = 1'b1;
                    csum_clr  = 1'b1;
                    idx_d     = 8'd0;
                    state_d   = ST_LEN;
                end
            end
            ST_LEN: begin
                if (slot_free) begin
                    m_data_d  = LEN_BYTE;
                    m_valid_d = 1'b1;
                    state_d   = ST_PAYLOAD;
                end
            end
            ST_PAYLOAD: begin
                if (pop) begin
                    m_data_d  = fifo_dout;
                    m_valid_d = 1'b1;
                    idx_d     = idx_q + 8'd1;
                    if (idx_q == LAST_IDX) begin
                        state_d = ST_CSUM;
                    end
                end else if (slot_free) begin
                    underrun_d = 1'b1;
                end
            end
            ST_CSUM: begin
                if (slot_free) begin
                    m_data_d  = csum;
                    m_valid_d = 1'b1;
                    m_last_d  = 1'b1;
                    state_d   = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        frame_cnt_d = frame_cnt_q;
        if (m_valid_q && m_ready && m_last_q) begin
            frame_cnt_d = frame_cnt_q + 16'd1;
        end
    end

    always_ff @(posedge sys_clk or negedge sys_rst) begin
        if (!sys_rst) begin
            state_q     <= ST_IDLE;
            m_data_q    <= 8'd0;
            m_valid_q   <= 1'b0;
            m_last_q    <= 1'b0;
            idx_q       <= 8'd0;
            underrun_q  <= 1'b0;
            frame_cnt_q <= 16'd0;
        end else begin
            state_q     <= state_d;
            m_data_q    <= m_data_d;
            m_valid_q   <= m_valid_d;
            m_last_q    <= m_last_d;
            idx_q       <= idx_d;
            underrun_q  <= underrun_d;
            frame_cnt_q <= frame_cnt_d;
        end
    end

    assign fifo_rd_en = pop;
    assign m_data     = m_data_q;
    assign m_valid    = m_valid_q;
    assign m_last     = m_last_q;
    assign busy       = (state_q != ST_IDLE);
    assign underrun   = underrun_q;
    assign frame_cnt  = frame_cnt_q;

endmodule
